// File: rtl/smc_seq_ctrl_if.sv
// Bus bundle for smc_seq_ctrl: parameter beats in, busy/result strobe out.
// The err line exists only when SMC_TIMEOUT_EN is defined.
interface smc_seq_ctrl_if;
    logic       in_valid;
    logic [1:0] mode;
    logic [2:0] W;
    logic [2:0] V_GS;
    logic [2:0] V_DS;
    logic       busy;
    logic       out_valid;
    logic [9:0] out_n;
`ifdef SMC_TIMEOUT_EN
    logic       err;

    modport master (output in_valid, mode, W, V_GS, V_DS,
                    input  busy, out_valid, out_n, err);
    modport slave  (input  in_valid, mode, W, V_GS, V_DS,
                    output busy, out_valid, out_n, err);
`else
    modport master (output in_valid, mode, W, V_GS, V_DS,
                    input  busy, out_valid, out_n);
    modport slave  (input  in_valid, mode, W, V_GS, V_DS,
                    output busy, out_valid, out_n);
`endif
endinterface

// File: rtl/smc_seq_ctrl.sv
// Sequential MOSFET I_D/g_m evaluator: serial load, one shared compute unit, running sort.
// Optional load-gap watchdog with err pulse when SMC_TIMEOUT_EN is defined.
module smc_seq_ctrl #(
    parameter int NUM_T       = 6,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    smc_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, SUM, OUT} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q;
    logic [1:0] mode_q;
    logic [2:0] w_q   [NUM_T];
    logic [2:0] vgs_q [NUM_T];
    logic [2:0] vds_q [NUM_T];
    logic [6:0] sort_q [NUM_T];
    logic [6:0] sort_d [NUM_T];
    logic [6:0] eval_res;
    logic [9:0] res_q;
    logic       last_beat;
    logic       timeout;

    // Shared per-transistor unit; operands widened to 10 bits so no product wraps.
    function automatic logic [6:0] eval_t(input logic [2:0] w, input logic [2:0] vgs,
                                          input logic [2:0] vds, input logic id_mode);
        logic [9:0] w10, vds10, vov, prod;
        w10   = {7'd0, w};
        vds10 = {7'd0, vds};
        vov   = {7'd0, vgs} - 10'd1;
        if (vgs == 3'd0)
            prod = '0;
        else if (vov > vds10)
            prod = id_mode ? w10 * vds10 * (10'd2 * vov - vds10) : 10'd2 * w10 * vds10;
        else
            prod = id_mode ? w10 * vov * vov : 10'd2 * w10 * vov;
        return 7'(prod / 10'd3);
    endfunction

    function automatic logic [9:0] weigh(input logic [6:0] s0, input logic [6:0] s1,
                                         input logic [6:0] s2, input logic weighted);
        logic [9:0] a, b, c;
        a = {3'd0, s0};
        b = {3'd0, s1};
        c = {3'd0, s2};
        return weighted ? (10'd3 * a + 10'd4 * b + 10'd5 * c) : (a + b + c);
    endfunction

    assign last_beat = bus.in_valid && (cnt_q == 3'(NUM_T - 1));

`ifdef SMC_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
    logic [GAP_W-1:0] gap_q;
    logic             err_q;

    assign timeout = (state_q == LOAD) && !bus.in_valid && (gap_q == GAP_W'(TIMEOUT_CYC - 1));
    assign bus.err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state_q != LOAD || bus.in_valid || timeout)
                gap_q <= '0;
            else
                gap_q <= gap_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = LOAD;
            LOAD: begin
                if (last_beat)    state_d = CALC;
                else if (timeout) state_d = IDLE;
            end
            CALC: if (cnt_q == 3'(NUM_T - 1)) state_d = SUM;
            SUM:  state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Descending insert; an equal entry stays ahead of the newcomer.
    always_comb begin
        eval_res  = eval_t(w_q[cnt_q], vgs_q[cnt_q], vds_q[cnt_q], mode_q[0]);
        sort_d[0] = (sort_q[0] >= eval_res) ? sort_q[0] : eval_res;
        for (int i = 1; i < NUM_T; i++)
            sort_d[i] = (sort_q[i] >= eval_res)   ? sort_q[i] :
                        (sort_q[i-1] >= eval_res) ? eval_res  : sort_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            for (int i = 0; i < NUM_T; i++) begin
                w_q[i]    <= '0;
                vgs_q[i]  <= '0;
                vds_q[i]  <= '0;
                sort_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    mode_q   <= bus.mode;
                    w_q[0]   <= bus.W;
                    vgs_q[0] <= bus.V_GS;
                    vds_q[0] <= bus.V_DS;
                    cnt_q    <= 3'd1;
                    for (int i = 0; i < NUM_T; i++) sort_q[i] <= '0;
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        w_q[cnt_q]   <= bus.W;
                        vgs_q[cnt_q] <= bus.V_GS;
                        vds_q[cnt_q] <= bus.V_DS;
                        cnt_q        <= last_beat ? 3'd0 : cnt_q + 3'd1;
                    end else if (timeout) begin
                        cnt_q  <= '0;
                        mode_q <= '0;
                        for (int i = 0; i < NUM_T; i++) begin
                            w_q[i]    <= '0;
                            vgs_q[i]  <= '0;
                            vds_q[i]  <= '0;
                            sort_q[i] <= '0;
                        end
                    end
                end
                CALC: begin
                    for (int i = 0; i < NUM_T; i++) sort_q[i] <= sort_d[i];
                    cnt_q <= (cnt_q == 3'(NUM_T - 1)) ? 3'd0 : cnt_q + 3'd1;
                end
                SUM: begin
                    if (mode_q[1]) res_q <= weigh(sort_q[0], sort_q[1], sort_q[2], mode_q[0]);
                    else           res_q <= weigh(sort_q[3], sort_q[4], sort_q[5], mode_q[0]);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_n     = (state_q == OUT) ? res_q : 10'd0;

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Bench for smc_seq_ctrl: spec-level model checked every cycle plus literal results.
module tb_smc_seq_ctrl;
    localparam int TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    smc_seq_ctrl_if bus();
    smc_seq_ctrl #(.NUM_T(6), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;

    int nvalid = 0, last_n = 0, last_cyc = 0, nerr = 0;
    int pw[6], pv[6], pd[6];

    // Model state: phase 0 idle, 1 collecting beats, 2 computing/output countdown
    int ph = 0, nb = 0, wt = 0, gap = 0, m_mode = 0, e_res = 0;
    int m_w[6], m_v[6], m_d[6];
    bit e_busy = 0, e_valid = 0, e_err = 0;
    int e_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_val(input int w, input int vgs, input int vds, input bit id);
        int vov;
        if (vgs == 0) return 0;
        vov = vgs - 1;
        if (vov > vds) return id ? (w * vds * (2 * vov - vds)) / 3 : (2 * w * vds) / 3;
        return id ? (w * vov * vov) / 3 : (2 * w * vov) / 3;
    endfunction

    function automatic int ref_out();
        int v[6];
        int t, b;
        for (int i = 0; i < 6; i++) v[i] = ref_val(m_w[i], m_v[i], m_d[i], m_mode[0]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        b = m_mode[1] ? 0 : 3;
        return m_mode[0] ? 3 * v[b] + 4 * v[b+1] + 5 * v[b+2] : v[b] + v[b+1] + v[b+2];
    endfunction

    // Spec-level model: mode from first beat, result visible 8 edges after beat 5
    initial forever begin
        @(posedge clk);
        cyc++;
        e_err = 0;
        if (!rst_n) begin
            ph = 0; nb = 0; wt = 0; gap = 0;
        end else begin
            case (ph)
                0: if (bus.in_valid) begin
                    m_mode = bus.mode;
                    m_w[0] = bus.W; m_v[0] = bus.V_GS; m_d[0] = bus.V_DS;
                    nb = 1; gap = 0; ph = 1;
                end
                1: if (bus.in_valid) begin
                    m_w[nb] = bus.W; m_v[nb] = bus.V_GS; m_d[nb] = bus.V_DS;
                    nb++; gap = 0;
                    if (nb == 6) begin ph = 2; wt = 0; e_res = ref_out(); end
                end else begin
`ifdef SMC_TIMEOUT_EN
                    gap++;
                    if (gap == TIMEOUT_CYC) begin ph = 0; nb = 0; e_err = 1; end
`endif
                end
                default: begin
                    wt++;
                    if (wt == 8) ph = 0;
                end
            endcase
        end
        e_busy  = (ph != 0);
        e_valid = (ph == 2 && wt == 7);
        e_n     = e_valid ? e_res : 0;
        started = 1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("busy", 32'(bus.busy), 32'(e_busy));
            check("out_valid", 32'(bus.out_valid), 32'(e_valid));
            check("out_n", 32'(bus.out_n), 32'(e_n));
`ifdef SMC_TIMEOUT_EN
            check("err", 32'(bus.err), 32'(e_err));
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin nvalid++; last_n = bus.out_n; last_cyc = cyc; end
`ifdef SMC_TIMEOUT_EN
        if (bus.err === 1'b1) nerr++;
`endif
    end

    task automatic beat(input int w, input int v, input int d, input int md);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode = 2'(md); bus.W = 3'(w); bus.V_GS = 3'(v); bus.V_DS = 3'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.W = '0; bus.V_GS = '0; bus.V_DS = '0;
        end
    endtask

    task automatic set_pat(input int w[6], input int v[6], input int d[6]);
        pw = w; pv = v; pd = d;
    endtask

    // Beats 1..5 carry an inverted mode to show only the first beat's mode is latched
    task automatic run(input int md, input int gp, output int e0);
        for (int i = 0; i < 6; i++) begin
            beat(pw[i], pv[i], pd[i], (i == 0) ? md : (md ^ 3));
            if (i < 5 && gp > 0) idle(gp);
        end
        @(negedge clk);
        e0 = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Latency counts the rising edge that captures the strobe, from the beat-5 edge
    task automatic wait_res(input string nm, input int e0, input int n0, input int exp);
        int k;
        k = 0;
        while (nvalid == n0 && k < 20) begin @(posedge clk); k++; end
        if (nvalid == n0) begin
            check({nm, "_timeout"}, 32'(0), 32'(1));
        end else begin
            check({nm, "_value"}, 32'(last_n), 32'(exp));
            check({nm, "_latency"}, 32'(last_cyc - e0 + 1), 32'(8));
        end
        idle(2);
    endtask

    int base_w[6] = '{7, 3, 2, 6, 5, 1};
    int base_v[6] = '{7, 4, 2, 5, 3, 6};
    int base_d[6] = '{7, 1, 5, 2, 3, 6};
    int max_w[6]  = '{7, 7, 7, 7, 7, 7};

    initial begin
        int e0, n0;
        bus.in_valid = 1'b0; bus.mode = '0; bus.W = '0; bus.V_GS = '0; bus.V_DS = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_out_valid", 32'(bus.out_valid), 32'(0));
        check("reset_out_n", 32'(bus.out_n), 32'(0));
        rst_n = 1'b1;
        idle(2);

        set_pat(base_w, base_v, base_d);
        n0 = nvalid; run(3, 0, e0); wait_res("id_largest", e0, n0, 388);
        n0 = nvalid; run(1, 0, e0); wait_res("id_smallest", e0, n0, 38);
        n0 = nvalid; run(2, 0, e0); wait_res("gm_largest", e0, n0, 42);
        n0 = nvalid; run(0, 0, e0); wait_res("gm_smallest", e0, n0, 6);

        set_pat(max_w, max_w, max_w);
        n0 = nvalid; run(3, 0, e0); wait_res("max_out", e0, n0, 1008);
        n0 = nvalid; run(3, 3, e0); wait_res("max_gapped", e0, n0, 1008);

        // Reset lands on the edge ending CALC cycle 3
        set_pat(base_w, base_v, base_d);
        n0 = nvalid; run(3, 0, e0);
        while (cyc < e0 + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_out_valid", 32'(bus.out_valid), 32'(0));
        check("abort_out_n", 32'(bus.out_n), 32'(0));
        rst_n = 1'b1;
        idle(12);
        check("abort_no_strobe", 32'(nvalid), 32'(n0));
        n0 = nvalid; run(3, 0, e0); wait_res("after_abort", e0, n0, 388);

        // in_valid held for 10 cycles: beats 7..10 must be dropped
        n0 = nvalid;
        for (int i = 0; i < 6; i++) beat(pw[i], pv[i], pd[i], 3);
        @(negedge clk);
        e0 = cyc;
        bus.W = 3'd7; bus.V_GS = 3'd7; bus.V_DS = 3'd7; bus.mode = 2'd0;
        repeat (3) beat(7, 7, 7, 0);
        idle(1);
        wait_res("held_valid", e0, n0, 388);
        idle(10);
        check("held_single_strobe", 32'(nvalid), 32'(n0 + 1));

`ifdef SMC_TIMEOUT_EN
        n0 = nvalid;
        for (int i = 0; i < 3; i++) beat(pw[i], pv[i], pd[i], 3);
        idle(TIMEOUT_CYC + 3);
        check("timeout_err_pulses", 32'(nerr), 32'(1));
        check("timeout_busy", 32'(bus.busy), 32'(0));
        check("timeout_no_strobe", 32'(nvalid), 32'(n0));
        n0 = nvalid; run(3, 0, e0); wait_res("after_timeout", e0, n0, 388);
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/smc_seq_ctrl.md
Name: smc_seq_ctrl

Overview:
Sequential front-end and scheduler for the MOSFET current/transconductance evaluator.
- Accepts six transistor parameter sets serially over a valid-qualified bus.
- Time-multiplexes one shared per-transistor compute unit across all six.
- Maintains a running descending sort, then produces the weighted output sum with a single-cycle out_valid pulse.
- Replaces the fully parallel six-lane datapath with roughly one sixth of the arithmetic.

Parameters:
NUM_T, 6, transistors per pattern; fixed at 6 (selection takes 3 largest or 3 smallest)
TIMEOUT_CYC, 16, idle-gap limit during load; used only when SMC_TIMEOUT_EN is defined

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  beat qualifier for mode/W/V_GS/V_DS
mode  input  2  sampled on first beat only; bit0: 1=I_D, 0=g_m; bit1: 1=largest three, 0=smallest three
W  input  3  transistor width, unsigned
V_GS  input  3  gate-source voltage, unsigned
V_DS  input  3  drain-source voltage, unsigned
busy  output  1  high from first accepted beat until out_valid cycle inclusive
out_valid  output  1  one-cycle result strobe
out_n  output  10  result; 0 whenever out_valid=0

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, beat/compute counters=0, sort buffer=0, busy=0, out_valid=0, out_n=0. Applies from any state and aborts a pattern mid-load or mid-compute; no partial output.
- States: IDLE -> LOAD -> CALC -> SUM -> OUT -> IDLE.
- IDLE, in_valid=1:
  - Store beat 0 and latch mode.
  - Go to LOAD with count=1; busy=1.
- LOAD:
  - Each in_valid=1 cycle stores one beat and increments count.
  - Gaps (in_valid=0) are allowed and ignored.
  - The edge storing beat 5 moves to CALC.
- CALC: exactly 6 cycles. Cycle k evaluates transistor k in the shared unit and inserts the result into the 6-entry descending sort buffer. Ties keep earlier-inserted entries first.
- SUM: 1 cycle. Select s0,s1,s2 = buffer[0..2] if mode[1], else buffer[3..5].
  - mode[0]=1: out = 3*s0 + 4*s1 + 5*s2.
  - mode[0]=0: out = s0 + s1 + s2.
- OUT: out_valid=1 and out_n=result for exactly one cycle, then IDLE and busy=0.
- Latency: out_valid is high on the 8th rising edge after the edge that stored beat 5.
- in_valid=1 in CALC/SUM/OUT is ignored: beats are dropped, state is unaffected.
- A new pattern's first beat is accepted in the cycle after OUT (IDLE). Back-to-back patterns therefore have one idle cycle minimum.
- Per-transistor arithmetic (unsigned, floor division by 3, intermediates at least 10 bits):
  - V_GS=0: value=0 (cutoff).
  - Triode when (V_GS-1) > V_DS:
    - I_D = W*V_DS*(2*(V_GS-1)-V_DS)/3
    - g_m = 2*W*V_DS/3
  - Otherwise saturation:
    - I_D = W*(V_GS-1)^2/3
    - g_m = 2*W*(V_GS-1)/3
  - Maximum per-transistor value is 84, so the maximum out_n is 1008 and no overflow handling is needed.

Optional Feature:
SMC_TIMEOUT_EN
- Defined:
  - In LOAD, a gap counter counts consecutive in_valid=0 cycles and resets on each beat.
  - When it reaches TIMEOUT_CYC, the block returns to IDLE and clears all buffers.
  - Extra output port err (1 bit) pulses high for one cycle. No out_valid is produced.
  - err resets to 0.
- Undefined: LOAD waits indefinitely; no err port exists.

Test Plan:
- mode=2'b11; beats (W,V_GS,V_DS) = (7,7,7), (3,4,1), (2,2,5), (6,5,2), (5,3,3), (1,6,6).
  -> I_D values 84, 5, 0, 24, 6, 8. Sorted: 84, 24, 8, 6, 5, 0. out_n=388 exactly 8 edges after the last beat.
- Same beats, mode=2'b01 -> out_n=38. Same beats, mode=2'b10 (g_m: 28, 2, 1, 8, 6, 3) -> out_n=42. Same beats, mode=2'b00 -> out_n=6.
- All six beats (7,7,7), mode=2'b11 -> out_n=1008. Insert 3-cycle gaps between beats -> same result, latency counted from the last beat.
- rst_n=0 during CALC cycle 3 -> busy, out_valid and out_n are 0 next cycle and no out_valid follows. A fresh pattern afterwards yields its correct result.
- in_valid held high for 10 consecutive cycles -> only the first 6 beats are used; the others are ignored. Single out_valid; result matches the first six beats.
- With SMC_TIMEOUT_EN: 3 beats, then in_valid=0 for 16 cycles -> err pulses once, busy falls, no out_valid. Next 6-beat pattern computes correctly.
